// File: rtl/mima_pkg.sv
// ----------------------------------------------------------------------------
// mima_pkg : formats, opcodes and immediate limits shared by instr_enc  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package mima_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  // Queued entry: {err, instruction word}
  localparam int ENC_W = 33;

endpackage

`default_nettype wire

// File: rtl/instr_fifo.sv
// ----------------------------------------------------------------------------
// instr_fifo : power-of-two synchronous FIFO, occupancy-counted  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module instr_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_occ == '0);
  assign full   = (r_occ == OCC_W'(DEPTH));
  assign w_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_push = push && (!full || w_pop);
  assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + 1'b1;
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_enc.sv
// ----------------------------------------------------------------------------
// instr_enc : RV32I field-bundle encoder, stage-1 register + output FIFO  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module instr_enc
  import mima_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] count
);

  function automatic logic [ENC_W-1:0] encode(
    input logic [2:0]  f,
    input logic [6:0]  opc,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  r1,
    input logic [4:0]  r2,
    input logic [4:0]  rdd,
    input logic [31:0] im
  );
    logic signed [31:0] s;
    logic [31:0]        w;
    logic               err;
    s   = im;
    err = 1'b0;
    w   = {f7, r2, r1, f3, rdd, opc};
    case (f)
      FMT_R: err = 1'b0;
      FMT_I: begin
        w   = {im[11:0], r1, f3, rdd, opc};
        err = (s < IMM12_MIN) || (s > IMM12_MAX);
      end
      FMT_S: begin
        w   = {im[11:5], r2, r1, f3, im[4:0], opc};
        err = (s < IMM12_MIN) || (s > IMM12_MAX);
      end
      FMT_B: begin
        w   = {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], opc};
        err = (s < IMM13_MIN) || (s > IMM13_MAX) || im[0];
      end
      FMT_U: begin
        w   = {im[31:12], rdd, opc};
        err = (im[11:0] != 12'd0);
      end
      FMT_J: begin
        w   = {im[20], im[10:1], im[11], im[19:12], rdd, opc};
        err = (s < IMM21_MIN) || (s > IMM21_MAX) || im[0];
      end
      // Undefined format: word keeps the R layout but is flagged
      default: err = 1'b1;
    endcase
    return {err, w};
  endfunction

  logic             r_s1_valid;
  logic [ENC_W-1:0] r_s1_data;
  logic [ENC_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_s1_drain;

  assign out_valid  = !w_empty;
  assign w_pop      = out_valid && out_ready;
  assign w_s1_drain = r_s1_valid && (!w_full || w_pop);
  assign in_ready   = !rst && (!r_s1_valid || w_s1_drain);
  assign out_instr  = w_head[31:0];
  assign out_err    = w_head[32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else if (in_valid && in_ready) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= encode(fmt, opcode, funct3, funct7, rs1, rs2, rd, imm);
    end else if (w_s1_drain) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 16'd0;
    end else if (w_pop) begin
      count <= count + 16'd1;
    end
  end

  instr_fifo #(
    .WIDTH (ENC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_s1_drain),
    .push_data (r_s1_data),
    .pop       (out_ready),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_enc.sv
// ----------------------------------------------------------------------------
// tb_instr_enc : directed + randomized bench for instr_enc with a word-level model  (rev 1.0)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_instr_enc;
  import mima_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = 3'd0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [4:0]  rd = 5'd0;
  logic [31:0] imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] count;

  typedef struct {
    logic [31:0] word;
    logic        err;
    bit          chk_word;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] mcount = 16'd0;
  bit          dut_in_fire;
  bit          dut_out_fire;

  always #5 clk = ~clk;

  instr_enc #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .count(count)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned fld(input int unsigned u, input int hi, input int lo);
    return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Word-level reference: RV32I bit placement and immediate legality as plain arithmetic
  function automatic exp_t model(input int unsigned f, input int unsigned opc,
                                 input int unsigned f3, input int unsigned f7,
                                 input int unsigned r1, input int unsigned r2,
                                 input int unsigned rdv, input int unsigned im);
    exp_t   e;
    longint v;
    int unsigned base;
    v = longint'(int'(im));
    base = (f3 << 12) | opc;
    e.chk_word = 1'b1;
    e.err = 1'b0;
    e.acc = 0;
    e.word = 32'd0;
    case (f)
      int'(FMT_R): e.word = (f7 << 25) | (r2 << 20) | (r1 << 15) | (rdv << 7) | base;
      int'(FMT_I): begin
        e.word = (fld(im, 11, 0) << 20) | (r1 << 15) | (rdv << 7) | base;
        e.err  = (v < -2048) || (v > 2047);
      end
      int'(FMT_S): begin
        e.word = (fld(im, 11, 5) << 25) | (r2 << 20) | (r1 << 15) | (fld(im, 4, 0) << 7) | base;
        e.err  = (v < -2048) || (v > 2047);
      end
      int'(FMT_B): begin
        e.word = (fld(im, 12, 12) << 31) | (fld(im, 10, 5) << 25) | (r2 << 20) | (r1 << 15)
               | (fld(im, 4, 1) << 8) | (fld(im, 11, 11) << 7) | base;
        e.err  = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      int'(FMT_U): begin
        e.word = (fld(im, 31, 12) << 12) | (rdv << 7) | opc;
        e.err  = (fld(im, 11, 0) != 0);
      end
      int'(FMT_J): begin
        e.word = (fld(im, 20, 20) << 31) | (fld(im, 10, 1) << 21) | (fld(im, 11, 11) << 20)
               | (fld(im, 19, 12) << 12) | (rdv << 7) | opc;
        e.err  = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      end
      default: begin
        e.err = 1'b1;
        e.chk_word = 1'b0;
      end
    endcase
    return e;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge
  task automatic tick();
    exp_t e;
    bit   exp_ov;
    bit   exp_ir;
    bit   ifire;
    bit   ofire;
    #1;
    exp_ov = (q.size() > 0) && (q[0].acc < cyc);
    exp_ir = !rst && ((q.size() < DEPTH + 1) || (exp_ov && out_ready));
    chk("out_valid", out_valid, exp_ov);
    chk("in_ready", in_ready, exp_ir);
    chk("count", count, mcount);
    if (exp_ov) begin
      if (q[0].chk_word) chk("out_instr", out_instr, q[0].word);
      chk("out_err", out_err, q[0].err);
    end
    dut_in_fire  = in_valid && in_ready;
    dut_out_fire = out_valid && out_ready;
    ifire = in_valid && exp_ir;
    ofire = exp_ov && out_ready;
    e = model(fmt, opcode, funct3, funct7, rs1, rs2, rd, imm);
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      mcount = 16'd0;
    end else begin
      if (ofire) begin
        void'(q.pop_front());
        mcount++;
      end
      if (ifire) begin
        e.acc = cyc;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_bundle();
    int unsigned r;
    r = $urandom_range(0, 9);
    fmt    = (r <= 5) ? 3'(r) : ((r <= 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7)));
    opcode = 7'($urandom);
    funct3 = 3'($urandom);
    funct7 = 7'($urandom);
    rs1    = 5'($urandom);
    rs2    = 5'($urandom);
    rd     = 5'($urandom);
    case ($urandom_range(0, 4))
      0: imm = $urandom_range(0, 4095) - 32'd2048;
      1: imm = ($urandom_range(0, 4095) - 32'd2048) * 2;
      2: imm = ($urandom_range(0, 1048575) - 32'd524288) * 2;
      3: imm = $urandom;
      default: imm = $urandom & (($urandom_range(0, 1) != 0) ? 32'hFFFFF000 : 32'hFFFFFFFF);
    endcase
  endtask

  task automatic set_bundle(input logic [2:0] f, input logic [6:0] opc, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] rdv, input logic [31:0] im);
    fmt = f; opcode = opc; funct3 = f3; funct7 = f7;
    rs1 = r1; rs2 = r2; rd = rdv; imm = im;
  endtask

  // Send one bundle into an idle encoder and inspect the word one cycle later
  task automatic send_expect(input string tag, input logic [31:0] w, input logic err, input bit chk_w);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    tick();
    #1;
    chk({tag, "_valid"}, out_valid, 1'b1);
    if (chk_w) chk({tag, "_instr"}, out_instr, w);
    chk({tag, "_err"}, out_err, err);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int accepts;
    int nout;
    logic [15:0] base;

    // Reset and post-reset state
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_count", count, 16'h0);

    // ADDI x1, x0, 5: visible exactly one cycle after acceptance
    set_bundle(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("lat_early", out_valid, 1'b0);
    tick();
    #1;
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_instr", out_instr, 32'h00500093);
    chk("addi_err", out_err, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    set_bundle(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, -32'sd4);
    send_expect("beq_m4", 32'hFE208EE3, 1'b0, 1'b1);
    set_bundle(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd3);
    send_expect("beq_odd", 32'h0, 1'b1, 1'b0);
    set_bundle(FMT_J, OPC_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
    send_expect("jal_2k", 32'h001000EF, 1'b0, 1'b1);
    set_bundle(FMT_U, OPC_LUI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd3, 32'h12345001);
    send_expect("lui_low", 32'h0, 1'b1, 1'b0);
    set_bundle(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd4, 32'd2048);
    send_expect("addi_2048", 32'h0, 1'b1, 1'b0);
    set_bundle(FMT_S, OPC_STORE, 3'd2, 7'd0, 5'd2, 5'd3, 5'd0, -32'sd2048);
    send_expect("sw_m2048", 32'h80312023, 1'b0, 1'b1);
    set_bundle(3'd6, OPC_OP, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    send_expect("fmt_undef", 32'h0, 1'b1, 1'b0);

    // Randomized traffic with occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      rand_bundle();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Backpressure: FIFO_DEPTH+1 accepts, then drain in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    accepts = 0;
    for (int i = 0; i < 20; i++) begin
      rand_bundle();
      tick();
      if (!dut_in_fire) break;
      accepts++;
    end
    chk("fill_accepts", accepts, DEPTH + 1);
    in_valid = 1'b0;
    base = mcount;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    #1;
    chk("drain_count", count, base + 16'(DEPTH + 1));

    // Full pipe streaming at one word per cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_bundle();
      tick();
      if (!dut_in_fire) break;
    end
    out_ready = 1'b1;
    nout = 0;
    for (int i = 0; i < 100; i++) begin
      rand_bundle();
      tick();
      if (dut_out_fire) nout++;
    end
    chk("full_stream_outs", nout, 100);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Reset with two words buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_bundle();
      tick();
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_count", count, 16'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Count wrap 0xFFFF -> 0x0000
    in_valid = 1'b1;
    for (int i = 0; i < 70000 && mcount != 16'hFFFF; i++) begin
      rand_bundle();
      tick();
    end
    #1;
    chk("count_ffff", count, 16'hFFFF);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dut_out_fire) break;
    end
    #1;
    chk("count_wrap", count, 16'h0000);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_enc.md
INSTR_ENC -- requirements
Module: instr_enc

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 2, output buffer entries (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  field bundle valid.
REQ-005 SHALL have port: in_ready  output  1  encoder accepts bundle this cycle.
REQ-006 SHALL have port: fmt  input  3  instruction format (R, I, S, B, U, J).
REQ-007 SHALL have ports: opcode input 7, funct3 input 3, funct7 input 7, rs1 input 5, rs2 input 5, rd input 5; field values.
REQ-008 SHALL have port: imm  input  32  signed immediate as a byte offset or value.
REQ-009 SHALL have port: out_valid  output  1  encoded word available.
REQ-010 SHALL have port: out_ready  input  1  consumer takes word.
REQ-011 SHALL have port: out_instr  output  32  encoded RV32 instruction word.
REQ-012 SHALL have port: out_err  output  1  sideband flag accompanying out_instr; set when the word is invalid.
REQ-013 SHALL have port: count  output  16  number of words accepted by the consumer, wrapping.

Function
REQ-014 Input transfer SHALL occur when in_valid and in_ready are both high; output transfer SHALL occur when out_valid and out_ready are both high.
REQ-015 Encoding SHALL place opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25] per the RV32I format; fields unused by a format SHALL come from imm or be zero.
REQ-016 I-format SHALL use imm[11:0] in [31:20]; S SHALL use imm[11:5] in [31:25] and imm[4:0] in [11:7]; U SHALL use imm[31:12] in [31:12].
REQ-017 B-format SHALL scatter imm[12|10:5|4:1|11]; J-format SHALL scatter imm[20|10:1|11|19:12]; in both, imm[0] SHALL be dropped.
REQ-018 out_err SHALL be set for any of: I/S imm outside -2048..2047; B imm outside -4096..4094 or odd; J imm outside +-1 MiB or odd; U imm[11:0] nonzero; fmt value undefined.
REQ-019 An erroneous word SHALL still be encoded from the truncated fields and queued.
REQ-020 Encoding SHALL be registered: an accepted bundle SHALL enter a stage-1 register and become visible at out_instr no earlier than 1 cycle after acceptance (latency 1 when the buffer is empty).
REQ-021 The stage-1 word SHALL move into a FIFO of FIFO_DEPTH entries; out_instr/out_err SHALL be the FIFO head, combinationally valid whenever out_valid is high.
REQ-022 in_ready SHALL be high iff stage 1 is empty or will drain this cycle, with the FIFO not full; in_ready SHALL NOT depend combinationally on in_valid.
REQ-023 Simultaneous push and pop on a full FIFO SHALL be permitted and SHALL keep occupancy constant.
REQ-024 Simultaneous push and pop on an empty FIFO SHALL NOT bypass; the pushed word SHALL appear the following cycle.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an occupancy counter of log2(FIFO_DEPTH)+1 bits.
REQ-026 out_instr SHALL hold stable while out_valid is high and out_ready is low.
REQ-027 count SHALL increment by 1 on each output transfer and SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-028 On rst high at a clock edge: stage 1 empty, FIFO empty, pointers 0, count 0, out_valid 0, out_instr 0, out_err 0.
REQ-029 in_ready SHALL be 0 during the reset cycle and 1 in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-stream SHALL discard all buffered words; no partial word SHALL emerge afterwards.

Structure
REQ-031 The format enum (R, I, S, B, U, J), the opcode constants and the immediate range limits SHALL live in the shared package mima_pkg.
REQ-032 The FIFO SHALL be a sub-module named instr_fifo, parameterised by width (33 = word + err) and depth; encoding SHALL be a pure function inside instr_enc.

Verification
REQ-033 Reset, then fmt=I, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_instr=0x00500093, out_err=0, out_valid exactly 1 cycle after acceptance.
REQ-034 fmt=B, opcode=0x63, funct3=0, rs1=1, rs2=2, imm=-4 -> out_instr=0xFE208EE3, out_err=0; the same bundle with imm=3 -> out_err=1.
REQ-035 fmt=J, opcode=0x6F, rd=1, imm=2048 -> out_instr=0x001000EF; fmt=U with imm=0x12345001 -> out_err=1.
REQ-036 Hold out_ready=0 and stream bundles -> in_ready falls after FIFO_DEPTH+1 accepts; release -> words exit in order, none lost or duplicated, count=FIFO_DEPTH+1.
REQ-037 Full FIFO with in_valid=1 and out_ready=1 every cycle for 100 cycles -> 100 words out in order, occupancy constant.
REQ-038 Assert rst with 2 words buffered -> next cycle out_valid=0 and count=0; preload count=0xFFFF then one transfer -> count=0x0000.
